// File: rtl/tl_memory.sv
// MIPS MEM stage: data memory with byte/half/word access, BEQ/BNE resolve, MEM/WB register. Optional DATA_MEM_DEBUG_EN adds a debug read port.
// Latency: loads and the MEM/WB register are updated on the falling edge after EX/MEM is presented; branch/forwarding outputs are combinational.
// Backpressure: i_enable=0 stalls the stage (no store, MEM/WB holds); synchronous active-low i_rst overrides the stall.
module tl_memory #(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_CTRL_MEM          = 9,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_ADDR_MEM          = 10
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_enable,
  input  logic [LEN-1:0]                  i_alu_result,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic [LEN-1:0]                  i_pc_branch,
  input  logic                            i_alu_zero,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  output logic                            o_pc_src,
  output logic [LEN-1:0]                  o_pc_branch,
  output logic [LEN-1:0]                  o_rd_mem_corto,
  output logic [LEN-1:0]                  o_read_data,
  output logic [LEN-1:0]                  o_alu_result,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic                            o_misaligned
`ifdef DATA_MEM_DEBUG_EN
  ,
  input  logic [NB_ADDR_MEM-1:0]          i_debug_addr,
  output logic [LEN-1:0]                  o_debug_data
`endif
);

  localparam int NB_LANE = LEN / 8;

  logic [LEN-1:0] mem [2**NB_ADDR_MEM];

  logic       beq, bne, mem_rd, mem_wr, ld_uns;
  logic [1:0] size;
  assign beq    = i_ctrl_mem[8];
  assign bne    = i_ctrl_mem[7];
  assign mem_rd = i_ctrl_mem[6];
  assign mem_wr = i_ctrl_mem[5];
  assign size   = i_ctrl_mem[4:3];
  assign ld_uns = i_ctrl_mem[2];

  logic [NB_ADDR_MEM-1:0] word_idx;
  logic [1:0]             byte_off;
  assign word_idx = i_alu_result[NB_ADDR_MEM+1:2];
  assign byte_off = i_alu_result[1:0];

  logic misaligned, access_err, do_store;
  assign misaligned = ((size == 2'b01) & byte_off[0]) | (size[1] & (byte_off != 2'b00));
  assign access_err = (mem_rd | mem_wr) & misaligned;
  assign do_store   = i_rst & i_enable & mem_wr & ~misaligned;

  // Store data is replicated across lanes so the lane enables alone select what lands.
  logic [NB_LANE-1:0] lane_en;
  logic [LEN-1:0]     wr_data;
  always_comb begin
    lane_en = '0;
    wr_data = i_dato2;
    case (size)
      2'b00: begin
        lane_en[byte_off] = 1'b1;
        wr_data           = {NB_LANE{i_dato2[7:0]}};
      end
      2'b01: begin
        lane_en[{byte_off[1], 1'b0}] = 1'b1;
        lane_en[{byte_off[1], 1'b1}] = 1'b1;
        wr_data                      = {(LEN/16){i_dato2[15:0]}};
      end
      default: lane_en = '1;
    endcase
  end

  always_ff @(negedge i_clk) begin
    if (do_store) begin
      for (int k = 0; k < NB_LANE; k++) begin
        if (lane_en[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Asynchronous read sees pre-write content, so a combined read+write returns old data.
  logic [LEN-1:0] rd_word, load_data;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign rd_half = rd_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    if (mem_rd && !misaligned) begin
      case (size)
        2'b00:   load_data = ld_uns ? {{(LEN-8){1'b0}}, rd_byte}
                                    : {{(LEN-8){rd_byte[7]}}, rd_byte};
        2'b01:   load_data = ld_uns ? {{(LEN-16){1'b0}}, rd_half}
                                    : {{(LEN-16){rd_half[15]}}, rd_half};
        default: load_data = rd_word;
      endcase
    end
  end

  always_ff @(negedge i_clk) begin
    if (!i_rst) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_ctrl_wb    <= '0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_read_data  <= load_data;
      o_alu_result <= i_alu_result;
      o_write_reg  <= i_write_reg;
      o_ctrl_wb    <= i_ctrl_wb;
      if (access_err) o_misaligned <= 1'b1;
    end
  end

  assign o_pc_src       = (beq & i_alu_zero) | (bne & ~i_alu_zero);
  assign o_pc_branch    = i_pc_branch;
  assign o_rd_mem_corto = i_alu_result;

`ifdef DATA_MEM_DEBUG_EN
  assign o_debug_data = mem[i_debug_addr];
`endif

  logic unused_bits;
  assign unused_bits = ^{i_ctrl_mem[1:0], i_alu_result[LEN-1:NB_ADDR_MEM+2]};

endmodule

// File: doc/tl_memory.md
Name: tl_memory

Overview:
MEM stage of the MIPS pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register: ALU result, store data, branch target, zero flag, mem/wb control and destination register.
- Owns the data memory. Performs byte/half/word loads and stores with alignment checking, and resolves BEQ/BNE.
- Drives the MEM/WB pipeline register and the MEM-stage forwarding value.

Parameters:
LEN, 32, datapath width
NB_ADDRESS_REGISTROS, 5, register-file address width
NB_CTRL_MEM, 9, mem control width
NB_CTRL_WB, 2, wb control width
NB_ADDR_MEM, 10, data-memory word-address width (2^NB_ADDR_MEM words)

Ports:
i_clk  in  1  clock; all state updates on falling edge
i_rst  in  1  reset
i_enable  in  1  step/run enable from debug unit; low = stall
i_alu_result  in  LEN  effective address / ALU result
i_dato2  in  LEN  store data (rt)
i_pc_branch  in  LEN  branch target
i_alu_zero  in  1  ALU zero flag
i_ctrl_mem  in  NB_CTRL_MEM  [8]BEQ [7]BNE [6]MemRead [5]MemWrite [4:3]size(00 byte, 01 half, 1x word) [2]LoadUnsigned [1:0]reserved
i_ctrl_wb  in  NB_CTRL_WB  [1]RegWrite [0]MemtoReg
i_write_reg  in  NB_ADDRESS_REGISTROS  destination register
o_pc_src  out  1  take branch (combinational)
o_pc_branch  out  LEN  = i_pc_branch (combinational)
o_rd_mem_corto  out  LEN  = i_alu_result, forwarding to EX (combinational)
o_read_data  out  LEN  MEM/WB: load data
o_alu_result  out  LEN  MEM/WB: ALU result
o_write_reg  out  NB_ADDRESS_REGISTROS  MEM/WB: destination
o_ctrl_wb  out  NB_CTRL_WB  MEM/WB: wb control
o_misaligned  out  1  sticky misaligned-access flag

Behaviour:
- Reset: i_rst is synchronous, active-low.
  - Sampled on the falling edge.
  - Clears o_read_data, o_alu_result, o_write_reg, o_ctrl_wb and o_misaligned to 0.
  - Suppresses memory writes.
  - Memory contents are not cleared.
- Word index = i_alu_result[NB_ADDR_MEM+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^NB_ADDR_MEM. Byte lanes are little-endian: lane k = bits [8k+7:8k].
- Alignment:
  - Half is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Byte is never misaligned.
- Store (MemWrite=1, aligned, i_enable=1, i_rst=1): on the falling edge, write only the addressed lanes.
  - Byte: lane addr[1:0] <= i_dato2[7:0].
  - Half: lanes {2*addr[1]+1, 2*addr[1]} <= i_dato2[15:0].
  - Word: whole word <= i_dato2.
  - Other lanes are unchanged.
- Load data is read asynchronously from the array.
  - Byte/half: extract the addressed lane(s), then sign-extend, or zero-extend if LoadUnsigned=1.
  - Word: full word.
  - Misaligned load or MemRead=0: data = 0.
- Misaligned access with MemRead or MemWrite set:
  - The store is suppressed.
  - o_misaligned is set on the falling edge and stays 1 until reset.
- MEM/WB register: on the falling edge with i_enable=1, latch load data, i_alu_result, i_write_reg and i_ctrl_wb. With i_enable=0, hold all values and perform no write.
- o_pc_src = (BEQ & i_alu_zero) | (BNE & ~i_alu_zero). It is combinational and not gated by i_enable.
- Store-then-load to the same address in consecutive cycles returns the new data; the write completes before the next EX/MEM value arrives.
- Simultaneous MemRead and MemWrite: the store is performed, and the latched load data is the pre-write array content.
- Reset asserted mid-stall: reset wins over i_enable=0.

Optional Feature:
DATA_MEM_DEBUG_EN
- Defined: adds ports i_debug_addr (NB_ADDR_MEM, word index) and o_debug_data (LEN), an asynchronous read of that word for the debug unit. Independent of i_enable and i_rst.
- Undefined: the ports do not exist and no extra logic is built.

Test Plan:
- Word store then load: addr 0x8, data 0xDEADBEEF, then LW 0x8 with RegWrite/MemtoReg -> next falling edge: o_read_data=0xDEADBEEF, o_alu_result=0x8, o_ctrl_wb=2'b11.
- Byte/half extension: word 0x8 = 0x80F0_7F81.
  - LB 0x8 -> 0xFFFFFF81.
  - LBU 0x8 -> 0x00000081.
  - LH 0xA -> 0xFFFF80F0.
  - LHU 0xA -> 0x000080F0.
- Partial store: word 0x10 = 0x11223344; SB 0x11 with data 0xAA -> LW 0x10 = 0x1122AA44. SH 0x12 with 0xBEEF -> LW 0x10 = 0xBEEFAA44.
- Misaligned: SW 0x14 with 0x12345678 onto prior 0, then SW 0x15 with 0xFFFFFFFF -> LW 0x14 = 0x12345678. o_misaligned=1 and remains 1 through later aligned accesses until i_rst=0.
- Branch: BEQ with zero=1 -> o_pc_src=1, o_pc_branch=i_pc_branch; BEQ zero=0 -> 0; BNE zero=0 -> 1; BNE zero=1 -> 0.
- Stall/reset:
  - i_enable=0 with SW 0x20 -> memory unchanged and outputs hold.
  - i_rst=0 during i_enable=0 -> all MEM/WB outputs and o_misaligned = 0 at the next falling edge, and memory is retained.
